count_ctrl: RTL
===============

Name: count_ctrl

Overview:
- Upstream stage of dec_decoder: generates the 5-bit counter value that dec_decoder renders on HEX4/HEX3.
- Takes raw push-keys and slide switches; synchronises and debounces them.
- Runs a start/stop state machine and a tick prescaler.
- Produces a wrapping up/down count in 0..MAX_COUNT, plus status outputs for LEDs.

Parameters:
- TICK_DIV, 50_000_000: clock cycles per auto-count tick (1 Hz at 50 MHz); must be >= 2.
- DEBOUNCE_CYCLES, 500_000: cycles a synchronised key must hold a new level before it is accepted (10 ms at 50 MHz); must be >= 2.
- MAX_COUNT, 31: terminal count; legal range 1..31, since the output is 5 bits wide.

Ports:
- i_clk, input, 1: system clock.
- i_rst_n, input, 1: asynchronous, active-low reset.
- i_key_n, input, 3: raw keys, active-low, asynchronous to i_clk. [0] start/stop toggle, [1] step, [2] clear.
- i_sw_dir, input, 1: count direction; 1 = up, 0 = down. Asynchronous; passes through a 2-FF synchroniser, no debounce.
- o_count, output, 5: current count; drives dec_decoder i_data.
- o_running, output, 1: 1 while in state RUN.
- o_wrap, output, 1: one-cycle pulse on every wrap (MAX_COUNT->0 counting up, 0->MAX_COUNT counting down).

Behaviour:
- Reset (async assert, sync release):
  - o_count=0, o_running=0, o_wrap=0, state=STOP, prescaler=0.
  - Key synchronisers and debounced levels = 1 (released); debounce counters = 0; dir synchroniser = 1.
- Key path, per key:
  - 2-FF synchroniser, then debounce.
  - Debounce counter clears whenever sync == stable; otherwise it increments.
  - When counter == DEBOUNCE_CYCLES-1 and sync still differs: stable <= sync, counter <= 0.
  - Press event = registered 1->0 transition of stable; one cycle wide. Release generates no event.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- State machine (states STOP, RUN):
  - STOP --start/stop event--> RUN. Prescaler is forced to 0 on entry.
  - RUN --start/stop event--> STOP. Prescaler holds.
- Prescaler:
  - Counts only in RUN, over 0..TICK_DIV-1.
  - tick=1 in the cycle where prescaler == TICK_DIV-1, then wraps to 0.
  - First tick comes TICK_DIV cycles after entering RUN.
- Count update: at most one change per cycle, registered (visible the cycle after the event/tick). Priority:
  1. Clear event: o_count <= 0, prescaler <= 0. State is not changed. No o_wrap.
  2. Step event (in either state): one step in the current i_sw_dir direction.
  3. tick: one step in the current i_sw_dir direction. A tick coinciding with a step is dropped, not deferred.
- Step arithmetic:
  - Up: MAX_COUNT -> 0 with o_wrap=1; otherwise +1.
  - Down: 0 -> MAX_COUNT with o_wrap=1; otherwise -1.
  - o_count never leaves 0..MAX_COUNT.
- Simultaneous events:
  - A clear and a start/stop event in the same cycle both apply: count cleared and state toggled.
  - A step and a start/stop event in the same cycle both apply.
- Direction change takes effect at the next step or tick; it never modifies o_count by itself.
- Reset mid-operation: everything returns to reset values immediately. A key held through reset release produces a press event only after DEBOUNCE_CYCLES.
- Latency: raw key falling edge -> o_count change is DEBOUNCE_CYCLES+4 cycles, ±1 for synchroniser phase.

Decomposition:
- Package counter_pkg:
  - typedef enum logic {STOP, RUN} run_state_t.
  - Key index constants KEY_RUN=0, KEY_STEP=1, KEY_CLR=2.
  - Localparam COUNT_W=5.
- Sub-module key_debounce:
  - Ports: i_clk, i_rst_n, i_key_n, o_press.
  - Parameter DEBOUNCE_CYCLES.
  - Contains the synchroniser, debounce counter and edge detect; instantiated 3x.
- count_ctrl holds the dir synchroniser, FSM, prescaler and count register.

Test Plan:
- Bench parameters unless noted: TICK_DIV=10, DEBOUNCE_CYCLES=4, MAX_COUNT=31.
- Reset, then no key activity for 100 cycles -> o_count=0, o_running=0, o_wrap never asserted.
- Press key0 for 10 cycles, dir=1 -> o_running=1; o_count goes 1,2,3 at exactly 10-cycle spacing, first increment 10 cycles after o_running rises.
- MAX_COUNT=5, running up from 0 -> sequence 1..5,0; o_wrap high for exactly one cycle as 5->0. dir=0 from 0 -> 5, with o_wrap pulse.
- 2-cycle low glitch on key1 -> no count change. 10-cycle press of key1 while stopped at 7, dir=0 -> 6, once only.
- Step press timed so its event lands on the tick cycle, at count 12 dir=1 -> 13, not 14; next tick -> 14.
- Clear and start/stop pressed together while RUN at count 20 -> o_count=0, o_running=0. Assert i_rst_n=0 mid-count -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the count_ctrl counter front end.
//   run_state_t : start/stop state machine encoding
//   KEY_*       : bit positions of the individual keys within i_key_n
//   COUNT_W     : width of the count presented to dec_decoder
package counter_pkg;

  localparam int unsigned COUNT_W = 5;

  localparam int unsigned KEY_RUN  = 0;
  localparam int unsigned KEY_STEP = 1;
  localparam int unsigned KEY_CLR  = 2;
  localparam int unsigned NUM_KEYS = 3;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } run_state_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronises one raw active-low key, debounces it and emits a one-cycle
// press pulse on each accepted released->pressed transition.
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_key_n  : raw key, active-low, asynchronous to i_clk
//   o_press  : registered one-cycle pulse per accepted press
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_stable;
  logic             r_stable_d;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Synchroniser, debounce counter and falling-edge detect of the stable level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta     <= 1'b1;
      r_sync     <= 1'b1;
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_meta <= i_key_n;
      r_sync <= r_meta;

      // Any return to the accepted level restarts the qualification window.
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      r_stable_d <= r_stable;
      r_press    <= r_stable_d & ~r_stable;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/count_ctrl.sv
// Start/stop, step and clear control for the 5-bit counter shown by
// dec_decoder. Keys are debounced, direction is synchronised, a prescaler
// generates auto-count ticks while running, and the count wraps in
// 0..MAX_COUNT.
//   i_clk     : system clock
//   i_rst_n   : asynchronous active-low reset
//   i_key_n   : raw keys, active-low: [0] start/stop, [1] step, [2] clear
//   i_sw_dir  : count direction, 1 = up, 0 = down (asynchronous)
//   o_count   : current count
//   o_running : high while the state machine is in RUN
//   o_wrap    : one-cycle pulse on every wrap of the count
module count_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned MAX_COUNT       = 31
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_KEYS-1:0] i_key_n,
  input  logic               i_sw_dir,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_running,
  output logic               o_wrap
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = COUNT_W'(MAX_COUNT);

  logic [NUM_KEYS-1:0] w_press;
  logic                w_ev_run;
  logic                w_ev_step;
  logic                w_ev_clr;
  logic                w_tick;
  logic                w_do_step;
  logic [COUNT_W-1:0]  w_next_count;
  logic                w_next_wrap;

  logic                r_dir_meta;
  logic                r_dir_sync;
  run_state_t          r_state;
  logic                r_running;
  logic [PRESC_W-1:0]  r_presc;
  logic [COUNT_W-1:0]  r_count;
  logic                r_wrap;

  // One debouncer per key.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_key_n (i_key_n[g]),
      .o_press (w_press[g])
    );
  end

  assign w_ev_run  = w_press[KEY_RUN];
  assign w_ev_step = w_press[KEY_STEP];
  assign w_ev_clr  = w_press[KEY_CLR];

  // Direction switch synchroniser; no debounce since it only matters at a step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dir_meta <= 1'b1;
      r_dir_sync <= 1'b1;
    end else begin
      r_dir_meta <= i_sw_dir;
      r_dir_sync <= r_dir_meta;
    end
  end

  // Start/stop state machine with registered running flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= STOP;
      r_running <= 1'b0;
    end else if (w_ev_run) begin
      case (r_state)
        STOP: begin
          r_state   <= RUN;
          r_running <= 1'b1;
        end
        RUN: begin
          r_state   <= STOP;
          r_running <= 1'b0;
        end
        default: begin
          r_state   <= STOP;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign w_tick = (r_state == RUN) && (r_presc == PRESC_LAST);

  // Prescaler: restarts on clear or on entry to RUN, freezes on leaving RUN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
    end else if (w_ev_clr || (w_ev_run && (r_state == STOP))) begin
      r_presc <= '0;
    end else if ((r_state == RUN) && !w_ev_run) begin
      r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
    end
  end

  // Next count for a single step in the current direction, with wrap flag.
  always_comb begin
    w_do_step    = w_ev_step | w_tick;
    w_next_count = r_count;
    w_next_wrap  = 1'b0;
    if (r_dir_sync) begin
      if (r_count >= COUNT_MAX) begin
        w_next_count = '0;
        w_next_wrap  = 1'b1;
      end else begin
        w_next_count = r_count + COUNT_W'(1);
      end
    end else begin
      if (r_count == '0) begin
        w_next_count = COUNT_MAX;
        w_next_wrap  = 1'b1;
      end else begin
        w_next_count = r_count - COUNT_W'(1);
      end
    end
  end

  // Count register: clear wins; a step and a tick together make one step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_ev_clr) begin
        r_count <= '0;
      end else if (w_do_step) begin
        r_count <= w_next_count;
        r_wrap  <= w_next_wrap;
      end
    end
  end

  assign o_count   = r_count;
  assign o_running = r_running;
  assign o_wrap    = r_wrap;

endmodule
